// File: rtl/alu_op_decoder.sv
// -----------------------------------------------------------------------------
// alu_op_decoder
//
// Purpose:
//   Decode stage for RV32I-style instruction words. Produces a registered ALU
//   operation bundle (4-bit op code, register indices, operand-B immediate and
//   selects) behind valid/ready handshakes on both sides. A one-entry skid
//   buffer keeps in_ready registered while sustaining one instruction per cycle
//   under backpressure.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   in_valid        instruction word valid
//   in_ready        decoder can accept in_instr (registered)
//   in_instr[31:0]  instruction word
//   out_valid       decode bundle valid
//   out_ready       downstream accepts bundle
//   out_alu_op[3:0] ADD=1 SUB=2 AND=3 OR=4 XOR=5 NOT=6 SLL=7 SRL=8 SRA=9 ROL=A,
//                   0 = none/illegal
//   out_rs1[4:0]    source register 1 index
//   out_rs2[4:0]    source register 2 index, 0 when out_use_imm
//   out_rd[4:0]     destination register index, 0 when illegal
//   out_imm[XLEN-1:0] operand B immediate (sign-extended imm12, or zero-extended
//                   shamt for shifts)
//   out_use_imm     operand B comes from out_imm
//   out_illegal     instruction not decodable to an ALU op
//
// Optional feature (macro ALU_DEC_STATS_EN):
//   stat_decoded[31:0] counts every output transfer
//   stat_illegal[31:0] counts output transfers with out_illegal=1
// -----------------------------------------------------------------------------
module alu_op_decoder #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      out_alu_op,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_imm,
    output logic            out_use_imm,
    output logic            out_illegal
`ifdef ALU_DEC_STATS_EN
    ,
    output logic [31:0]     stat_decoded,
    output logic [31:0]     stat_illegal
`endif
);

    typedef enum logic [3:0] {
        OP_NONE = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_AND  = 4'h3,
        OP_OR   = 4'h4,
        OP_XOR  = 4'h5,
        OP_NOT  = 4'h6,
        OP_SLL  = 4'h7,
        OP_SRL  = 4'h8,
        OP_SRA  = 4'h9,
        OP_ROL  = 4'hA
    } alu_op_e;

    typedef struct packed {
        alu_op_e         alu_op;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        logic            use_imm;
        logic            illegal;
    } bundle_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] F7_ZERO    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;
    localparam logic [6:0] F7_ROT     = 7'b0110000;

    // Instruction fields
    logic [6:0]      w_opcode;
    logic [4:0]      w_rd;
    logic [2:0]      w_f3;
    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic [6:0]      w_f7;
    logic [11:0]     w_imm12;
    logic [XLEN-1:0] w_imm_sext;
    logic [XLEN-1:0] w_shamt_zext;

    assign w_opcode     = in_instr[6:0];
    assign w_rd         = in_instr[11:7];
    assign w_f3         = in_instr[14:12];
    assign w_rs1        = in_instr[19:15];
    assign w_rs2        = in_instr[24:20];
    assign w_f7         = in_instr[31:25];
    assign w_imm12      = in_instr[31:20];
    assign w_imm_sext   = {{(XLEN-12){in_instr[31]}}, w_imm12};
    assign w_shamt_zext = {{(XLEN-5){1'b0}}, w_rs2};

    // -------------------------------------------------------------------------
    // Combinational decode
    // -------------------------------------------------------------------------
    alu_op_e         w_op;
    logic            w_is_imm;
    logic            w_is_shift;
    bundle_t         w_dec;

    always_comb begin
        w_op       = OP_NONE;
        w_is_imm   = 1'b0;
        w_is_shift = 1'b0;

        case (w_opcode)
            OPC_OP: begin
                case (w_f3)
                    3'b000:  w_op = (w_f7 == F7_ZERO) ? OP_ADD :
                                    (w_f7 == F7_ALT)  ? OP_SUB : OP_NONE;
                    3'b111:  w_op = (w_f7 == F7_ZERO) ? OP_AND : OP_NONE;
                    3'b110:  w_op = (w_f7 == F7_ZERO) ? OP_OR  : OP_NONE;
                    3'b100:  w_op = (w_f7 == F7_ZERO) ? OP_XOR : OP_NONE;
                    3'b001:  w_op = (w_f7 == F7_ZERO) ? OP_SLL :
                                    (w_f7 == F7_ROT)  ? OP_ROL : OP_NONE;
                    3'b101:  w_op = (w_f7 == F7_ZERO) ? OP_SRL :
                                    (w_f7 == F7_ALT)  ? OP_SRA : OP_NONE;
                    default: w_op = OP_NONE;
                endcase
            end
            OPC_OP_IMM: begin
                w_is_imm = 1'b1;
                case (w_f3)
                    3'b000:  w_op = OP_ADD;
                    3'b111:  w_op = OP_AND;
                    3'b110:  w_op = OP_OR;
                    // xori with all-ones immediate is a bitwise NOT
                    3'b100:  w_op = (w_imm12 == 12'hFFF) ? OP_NOT : OP_XOR;
                    3'b001: begin
                        w_is_shift = 1'b1;
                        w_op = (w_f7 == F7_ZERO) ? OP_SLL : OP_NONE;
                    end
                    3'b101: begin
                        w_is_shift = 1'b1;
                        w_op = (w_f7 == F7_ZERO) ? OP_SRL :
                               (w_f7 == F7_ALT)  ? OP_SRA : OP_NONE;
                    end
                    default: w_op = OP_NONE;
                endcase
            end
            default: w_op = OP_NONE;
        endcase

        w_dec         = '0;
        w_dec.alu_op  = w_op;
        w_dec.rs1     = w_rs1;
        w_dec.rs2     = w_rs2;
        if (w_op == OP_NONE) begin
            // Illegal words still produce a bundle; rs1/rs2 pass through raw
            w_dec.illegal = 1'b1;
        end else begin
            w_dec.rd = w_rd;
            if (w_is_imm) begin
                w_dec.use_imm = 1'b1;
                w_dec.rs2     = '0;
                w_dec.imm     = w_is_shift ? w_shamt_zext : w_imm_sext;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Output register + one-entry skid buffer
    // -------------------------------------------------------------------------
    bundle_t r_out;
    logic    r_out_valid;
    bundle_t r_skid;
    logic    r_in_ready;   // skid entry is full exactly when this is low

    logic    w_skid_full;
    logic    w_accept;
    logic    w_drain;
    logic    w_out_free;

    assign w_skid_full = ~r_in_ready;
    assign w_accept    = in_valid & r_in_ready;
    assign w_drain     = r_out_valid & out_ready;
    assign w_out_free  = ~r_out_valid | out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_skid      <= '0;
            r_in_ready  <= 1'b1;
        end else if (w_skid_full) begin
            // No accept is possible while full; draining promotes the skid entry
            if (w_drain) begin
                r_out      <= r_skid;
                r_in_ready <= 1'b1;
            end
        end else if (w_accept) begin
            if (w_out_free) begin
                r_out       <= w_dec;
                r_out_valid <= 1'b1;
            end else begin
                r_skid     <= w_dec;
                r_in_ready <= 1'b0;
            end
        end else if (w_drain) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign out_alu_op  = r_out.alu_op;
    assign out_rs1     = r_out.rs1;
    assign out_rs2     = r_out.rs2;
    assign out_rd      = r_out.rd;
    assign out_imm     = r_out.imm;
    assign out_use_imm = r_out.use_imm;
    assign out_illegal = r_out.illegal;

`ifdef ALU_DEC_STATS_EN
    logic [31:0] r_stat_decoded;
    logic [31:0] r_stat_illegal;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_decoded <= '0;
            r_stat_illegal <= '0;
        end else if (w_drain) begin
            r_stat_decoded <= r_stat_decoded + 32'd1;
            if (r_out.illegal) begin
                r_stat_illegal <= r_stat_illegal + 32'd1;
            end
        end
    end

    assign stat_decoded = r_stat_decoded;
    assign stat_illegal = r_stat_illegal;
`endif

endmodule

// File: tb/tb_alu_op_decoder.sv
// -----------------------------------------------------------------------------
// tb_alu_op_decoder
//
// Self-checking bench for alu_op_decoder: directed vector table, hand-written
// backpressure and reset sequences, then randomized traffic scored against a
// rule-table decode model and an in-flight queue.
// Build with +define+ALU_DEC_STATS_EN to also check the statistics counters.
// -----------------------------------------------------------------------------
module tb_alu_op_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_alu_op;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [4:0]  out_rd;
    logic [31:0] out_imm;
    logic        out_use_imm;
    logic        out_illegal;
`ifdef ALU_DEC_STATS_EN
    logic [31:0] stat_decoded;
    logic [31:0] stat_illegal;
`endif

    always #5 clk = ~clk;

    alu_op_decoder #(.XLEN(32)) dut (
`ifdef ALU_DEC_STATS_EN
        .stat_decoded (stat_decoded),
        .stat_illegal (stat_illegal),
`endif
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_alu_op  (out_alu_op),
        .out_rs1     (out_rs1),
        .out_rs2     (out_rs2),
        .out_rd      (out_rd),
        .out_imm     (out_imm),
        .out_use_imm (out_use_imm),
        .out_illegal (out_illegal)
    );

    typedef struct packed {
        logic [3:0]  op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        use_imm;
        logic        illegal;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        exp_t        exp;
    } vec_t;

    typedef struct {
        logic [6:0] opc;
        logic [2:0] f3;
        logic       care;   // compare instr[31:25] against f7
        logic [6:0] f7;
        logic [3:0] op;
    } rule_t;

    int total = 0;
    int bad   = 0;
    int n_xfer = 0;
    int n_ill  = 0;
    exp_t  q[$];
    rule_t rules[16];
    vec_t  tbl[13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic exp_t got();
        return {out_alu_op, out_rs1, out_rs2, out_rd, out_imm, out_use_imm, out_illegal};
    endfunction

    task automatic init_rules();
        rules[0]  = '{7'h33, 3'b000, 1'b1, 7'h00, 4'h1};
        rules[1]  = '{7'h33, 3'b000, 1'b1, 7'h20, 4'h2};
        rules[2]  = '{7'h33, 3'b111, 1'b1, 7'h00, 4'h3};
        rules[3]  = '{7'h33, 3'b110, 1'b1, 7'h00, 4'h4};
        rules[4]  = '{7'h33, 3'b100, 1'b1, 7'h00, 4'h5};
        rules[5]  = '{7'h33, 3'b001, 1'b1, 7'h00, 4'h7};
        rules[6]  = '{7'h33, 3'b001, 1'b1, 7'h30, 4'hA};
        rules[7]  = '{7'h33, 3'b101, 1'b1, 7'h00, 4'h8};
        rules[8]  = '{7'h33, 3'b101, 1'b1, 7'h20, 4'h9};
        rules[9]  = '{7'h13, 3'b000, 1'b0, 7'h00, 4'h1};
        rules[10] = '{7'h13, 3'b111, 1'b0, 7'h00, 4'h3};
        rules[11] = '{7'h13, 3'b110, 1'b0, 7'h00, 4'h4};
        rules[12] = '{7'h13, 3'b100, 1'b0, 7'h00, 4'h5};
        rules[13] = '{7'h13, 3'b001, 1'b1, 7'h00, 4'h7};
        rules[14] = '{7'h13, 3'b101, 1'b1, 7'h00, 4'h8};
        rules[15] = '{7'h13, 3'b101, 1'b1, 7'h20, 4'h9};
    endtask

    // Reference decode: first matching rule wins, xori-all-ones checked first
    function automatic exp_t ref_decode(input logic [31:0] w);
        logic [3:0]  op = 4'h0;
        logic [31:0] imm;
        exp_t        e;
        if (w[6:0] == 7'h13 && w[14:12] == 3'b100 && w[31:20] == 12'hFFF)
            op = 4'h6;
        else
            for (int i = 0; i < 16; i++)
                if (op == 4'h0 && rules[i].opc == w[6:0] && rules[i].f3 == w[14:12] &&
                    (!rules[i].care || rules[i].f7 == w[31:25]))
                    op = rules[i].op;
        if (op == 4'h0)
            e = {4'h0, w[19:15], w[24:20], 5'd0, 32'd0, 1'b0, 1'b1};
        else if (w[6:0] == 7'h33)
            e = {op, w[19:15], w[24:20], w[11:7], 32'd0, 1'b0, 1'b0};
        else begin
            if (w[14:12] == 3'b001 || w[14:12] == 3'b101) imm = 32'(w[24:20]);
            else imm = 32'($signed(w[31:20]));
            e = {op, w[19:15], 5'd0, w[11:7], imm, 1'b1, 1'b0};
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w = $urandom;
        int k = $urandom_range(0, 9);
        if (k < 4) w[6:0] = 7'h33;
        else if (k < 8) w[6:0] = 7'h13;
        case ($urandom_range(0, 3))
            0: w[31:25] = 7'h00;
            1: w[31:25] = 7'h20;
            2: w[31:25] = 7'h30;
            default: ;
        endcase
        if ($urandom_range(0, 7) == 0) w[31:20] = 12'hFFF;
        return w;
    endfunction

    // One clock of scoreboarded traffic; returns just before the next posedge
    task automatic cycle(input logic v, input logic [31:0] ins, input logic rdy);
        exp_t e;
        @(negedge clk);
        in_valid = v; in_instr = ins; out_ready = rdy;
        #1;
        chk("out_valid_vs_occupancy", out_valid, q.size() > 0);
        chk("in_ready_vs_occupancy", in_ready, q.size() < 2);
        if (out_valid && out_ready && q.size() > 0) begin
            e = q.pop_front();
            chk("bundle", got(), e);
            n_xfer++;
            if (e.illegal) n_ill++;
        end
        if (in_valid && in_ready) q.push_back(ref_decode(ins));
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    localparam logic [31:0] I_ADD = 32'h002081B3;
    localparam logic [31:0] I_SUB = 32'h402081B3;
    localparam logic [31:0] I_ROL = 32'h603110B3;
    localparam logic [31:0] I_SLT = 32'h0020A1B3;

    initial begin
        init_rules();
        tbl[0]  = '{32'h002081B3, {4'h1, 5'd1,  5'd2, 5'd3,  32'd0,          1'b0, 1'b0}};
        tbl[1]  = '{32'h402081B3, {4'h2, 5'd1,  5'd2, 5'd3,  32'd0,          1'b0, 1'b0}};
        tbl[2]  = '{32'h40435293, {4'h9, 5'd6,  5'd0, 5'd5,  32'd4,          1'b1, 1'b0}};
        tbl[3]  = '{32'hFFF44393, {4'h6, 5'd8,  5'd0, 5'd7,  32'hFFFF_FFFF,  1'b1, 1'b0}};
        tbl[4]  = '{32'h603110B3, {4'hA, 5'd2,  5'd3, 5'd1,  32'd0,          1'b0, 1'b0}};
        tbl[5]  = '{32'h0020A1B3, {4'h0, 5'd1,  5'd2, 5'd0,  32'd0,          1'b0, 1'b1}};
        tbl[6]  = '{32'hFFF58513, {4'h1, 5'd11, 5'd0, 5'd10, 32'hFFFF_FFFF,  1'b1, 1'b0}};
        tbl[7]  = '{32'h01F09013, {4'h7, 5'd1,  5'd0, 5'd0,  32'd31,         1'b1, 1'b0}};
        tbl[8]  = '{32'h40109013, {4'h0, 5'd1,  5'd1, 5'd0,  32'd0,          1'b0, 1'b1}};
        tbl[9]  = '{32'h0000A083, {4'h0, 5'd1,  5'd0, 5'd0,  32'd0,          1'b0, 1'b1}};
        tbl[10] = '{32'h0FF37293, {4'h3, 5'd6,  5'd0, 5'd5,  32'h0000_00FF,  1'b1, 1'b0}};
        tbl[11] = '{32'h0062D233, {4'h8, 5'd5,  5'd6, 5'd4,  32'd0,          1'b0, 1'b0}};
        tbl[12] = '{32'h4062F233, {4'h0, 5'd5,  5'd6, 5'd0,  32'd0,          1'b0, 1'b1}};

        // Reset
        rst = 1'b1; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_in_ready", in_ready, 1'b1);
        chk("reset_fields", got(), '0);

        // Back-to-back directed vectors with out_ready=1: one bundle per cycle
        out_ready = 1'b1;
        for (int i = 0; i <= 13; i++) begin
            step();
            if (i > 0) begin
                chk($sformatf("vec%0d_valid", i - 1), out_valid, 1'b1);
                chk($sformatf("vec%0d_bundle", i - 1), got(), tbl[i - 1].exp);
            end
            chk("vec_in_ready", in_ready, 1'b1);
            if (i < 13) begin
                in_valid = 1'b1; in_instr = tbl[i].instr;
            end else begin
                in_valid = 1'b0;
            end
        end
        step();
        chk("vec_drained", out_valid, 1'b0);

        // Backpressure: three offered, two accepted, then in-order release
        step();
        chk("bp_ready0", in_ready, 1'b1);
        in_valid = 1'b1; in_instr = I_ADD; out_ready = 1'b0;
        step();
        chk("bp_valid1", out_valid, 1'b1);
        chk("bp_ready1", in_ready, 1'b1);
        in_instr = I_SUB;
        step();
        chk("bp_full_ready", in_ready, 1'b0);
        chk("bp_hold_a", got(), ref_decode(I_ADD));
        chk("bp_hold_a_op", out_alu_op, 4'h1);
        in_instr = I_ROL;
        step();
        chk("bp_still_full", in_ready, 1'b0);
        chk("bp_stable_a", got(), ref_decode(I_ADD));
        out_ready = 1'b1;
        step();
        chk("bp_b_valid", out_valid, 1'b1);
        chk("bp_b", got(), ref_decode(I_SUB));
        chk("bp_b_op", out_alu_op, 4'h2);
        chk("bp_ready_back", in_ready, 1'b1);
        step();
        chk("bp_c_valid", out_valid, 1'b1);
        chk("bp_c_op", out_alu_op, 4'hA);
        chk("bp_c_ready", in_ready, 1'b1);
        in_valid = 1'b0;
        step();
        chk("bp_empty", out_valid, 1'b0);

        // Reset with output register and skid both occupied
        in_valid = 1'b1; in_instr = I_ADD; out_ready = 1'b0;
        step();
        in_instr = I_SUB;
        step();
        chk("rst_pre_full", in_ready, 1'b0);
        chk("rst_pre_valid", out_valid, 1'b1);
        in_valid = 1'b0; rst = 1'b1;
        step();
        chk("rst_mid_valid", out_valid, 1'b0);
        chk("rst_mid_ready", in_ready, 1'b1);
        chk("rst_mid_fields", got(), '0);
        rst = 1'b0; out_ready = 1'b1;
        n_xfer = 0; n_ill = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rst_no_stale", out_valid, 1'b0);
        end

        // Single illegal word (slt)
        cycle(1'b1, I_SLT, 1'b1);
        cycle(1'b0, 32'h0, 1'b1);
        chk("slt_illegal", out_illegal, 1'b1);
        chk("slt_op", out_alu_op, 4'h0);
        chk("slt_rd", out_rd, 5'd0);
        cycle(1'b0, 32'h0, 1'b0);
`ifdef ALU_DEC_STATS_EN
        step();
        chk("slt_stat_decoded", stat_decoded, 32'd1);
        chk("slt_stat_illegal", stat_illegal, 32'd1);
`endif

        // Randomized traffic against the reference model
        for (int i = 0; i < 3000; i++)
            cycle($urandom_range(0, 9) < 7, rand_instr(), $urandom_range(0, 9) < 6);
        for (int i = 0; i < 4; i++)
            cycle(1'b0, 32'h0, 1'b1);
`ifdef ALU_DEC_STATS_EN
        step();
        chk("stat_decoded", stat_decoded, 32'(n_xfer));
        chk("stat_illegal", stat_illegal, 32'(n_ill));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
